mioc_gate_pattern_checker: RTL and testbench
============================================

// Module: mioc_gate_pattern_checker
//
// PURPOSE
// On-chip stimulus/response engine for MIOC 4-input gate test structures.
// It drives the gate inputs in1..in4 through all 16 patterns in ascending order.
// After each pattern settles, it samples the gate output z and compares it with a
// truth-table parameter. It reports the mismatch count, the first failing pattern
// and a pass flag.
// It sits between the test-control logic and one gate instance, e.g. the
// nand4/nor2 nmos cell.
//
// PARAMETERS
// SETTLE_CYC  4         idle cycles between driving a pattern and sampling; 1..255
// EXPECT_TT   16'h7FFF  expected z per pattern; bit index = {in1,in2,in3,in4}
//
// PORTS
// clk         in   1   single clock, rising-edge
// rst_n       in   1   asynchronous active-low reset
// start       in   1   run request, sampled only in IDLE
// z           in   1   gate output, asynchronous to clk
// in1         out  1   gate input, pattern bit 3 (MSB)
// in2         out  1   gate input, pattern bit 2
// in3         out  1   gate input, pattern bit 1
// in4         out  1   gate input, pattern bit 0 (LSB)
// busy        out  1   high from start accept until DONE is exited
// done        out  1   one-cycle pulse at end of run
// pass        out  1   err_cnt==0 for the last run; held until next start
// err_cnt     out  5   mismatches in the last run, 0..16
// first_fail  out  4   pattern index of the first mismatch; 0 if none
//
// BEHAVIOUR
// - Reset (async, rst_n=0): all outputs 0, FSM=IDLE, pattern=0, sync flops 0.
// - All outputs are registered; in1..in4 change only on clk edges.
// - z passes through a 2-flop synchronizer (z_s) before any use.
// - IDLE:
//   - in1..in4=0000, busy=0.
//   - start=1 -> clear err_cnt, first_fail, pass; pat=0; busy=1 -> APPLY.
// - APPLY (1 cyc): {in1,in2,in3,in4}<=pat; load settle counter -> SETTLE.
// - SETTLE: waits SETTLE_CYC+2 cycles (settle time plus synchronizer) -> SAMPLE.
// - SAMPLE (1 cyc):
//   - Mismatch when z_s != EXPECT_TT[pat]: err_cnt++.
//   - If err_cnt was 0, first_fail<=pat.
//   - pat==15 -> DONE; else pat++ -> APPLY.
// - DONE (1 cyc): done=1; pass<=(err_cnt==0); in1..in4<=0000 -> IDLE.
//   busy stays 1 during DONE and drops on entry to IDLE.
// - Timing:
//   - Each pattern is held on in1..in4 for exactly SETTLE_CYC+4 cycles.
//   - done is high in cycle 16*(SETTLE_CYC+4)+1 after the edge that accepted start.
// - Width rules:
//   - err_cnt is 5 bits, so 16 fits with no saturation logic.
//   - pat is 4 bits; wrap never occurs because 15 exits to DONE.
// - start while busy (incl. DONE) is ignored.
// - start held high across DONE->IDLE begins a new run on the next cycle.
// - rst_n low mid-run aborts at once to the reset state; results are lost.
//   No done pulse is produced.
// - err_cnt, first_fail and pass stay stable in IDLE until the next accepted start.
//
// CONFIGURATION
// MIOC_SIGNATURE_EN defined:
// - Adds output sig [15:0], a MISR over the sampled responses.
// - Polynomial x^16+x^12+x^5+1.
// - Seeded 16'hFFFF on start accept; 0 at reset.
// - Each SAMPLE: sig <= {sig[14:0],1'b0} ^ ({16{sig[15]^z_s}} & 16'h1021).
// - Final value is held in IDLE.
// MIOC_SIGNATURE_EN undefined: no sig port, no MISR logic; all other behaviour is identical.
//
// TESTING
// 1 Reset: rst_n=0 for 3 cyc, z=X -> all outputs 0, busy=0, in1..4=0000.
// 2 Ideal model (z=EXPECT_TT[{in1..4}] with 2-cyc delay), SETTLE_CYC=4, start pulse:
//   - Patterns 0..15 appear in order, 8 cyc each.
//   - done in cycle 129; pass=1, err_cnt=0, first_fail=0.
// 3 z stuck-at-1, default EXPECT_TT -> err_cnt=1, first_fail=4'hF, pass=0.
// 4 z stuck-at-0 -> err_cnt=15, first_fail=4'h0, pass=0.
// 5 Start handling and abort:
//   - start held high through a whole run -> start is ignored while busy.
//   - rst_n pulsed low at pattern 7 -> async clear, no done pulse.
//   - Following clean run -> identical to scenario 2.
// 6 MIOC_SIGNATURE_EN:
//   - Ideal run -> sig equals the bench MISR reference.
//   - Injected z error at pattern 5 -> sig differs.
//   - Repeated ideal run -> same sig as the first ideal run.

Source files
------------

// File: rtl/mioc_gate_pattern_checker.sv
// ============================================================================
// Module  : mioc_gate_pattern_checker
// Brief   : Drives a 4-input gate through all 16 patterns in order and checks
//           the synchronized response against a truth table. The MISR
//           signature output is enabled by MIOC_SIGNATURE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mioc_gate_pattern_checker #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter logic [15:0] EXPECT_TT  = 16'h7FFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       z,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       in4,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [3:0] first_fail
`ifdef MIOC_SIGNATURE_EN
  ,
  output logic [15:0] sig
`endif
);

  // SETTLE lasts SETTLE_CYC+2 cycles; the counter counts down to zero inclusive.
  localparam logic [8:0] C_SETTLE_LOAD = 9'(SETTLE_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  pat_q, pat_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [3:0]  gate_q, gate_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [4:0]  err_q, err_d;
  logic [3:0]  ff_q, ff_d;
  logic        z_meta_q, z_s_q;
  logic [15:0] sig_q, sig_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pat_q    <= 4'd0;
      cnt_q    <= 9'd0;
      gate_q   <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 5'd0;
      ff_q     <= 4'd0;
      z_meta_q <= 1'b0;
      z_s_q    <= 1'b0;
      sig_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      cnt_q    <= cnt_d;
      gate_q   <= gate_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      ff_q     <= ff_d;
      z_meta_q <= z;
      z_s_q    <= z_meta_q;
      sig_q    <= sig_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    gate_d  = gate_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;
    sig_d   = sig_q;
    case (state_q)
      S_IDLE: begin
        gate_d = 4'd0;
        busy_d = 1'b0;
        if (start) begin
          err_d   = 5'd0;
          ff_d    = 4'd0;
          pass_d  = 1'b0;
          pat_d   = 4'd0;
          busy_d  = 1'b1;
          sig_d   = 16'hFFFF;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        gate_d  = pat_q;
        cnt_d   = C_SETTLE_LOAD;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == 9'd0) state_d = S_SAMPLE;
        else               cnt_d   = cnt_q - 9'd1;
      end
      S_SAMPLE: begin
        if (z_s_q != EXPECT_TT[pat_q]) begin
          err_d = err_q + 5'd1;
          if (err_q == 5'd0) ff_d = pat_q;
        end
        sig_d = {sig_q[14:0], 1'b0} ^ ({16{sig_q[15] ^ z_s_q}} & 16'h1021);
        if (pat_q == 4'd15) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          pat_d   = pat_q + 4'd1;
          state_d = S_APPLY;
        end
      end
      S_DONE: begin
        pass_d  = (err_q == 5'd0);
        gate_d  = 4'd0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign {in1, in2, in3, in4} = gate_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign first_fail = ff_q;

`ifdef MIOC_SIGNATURE_EN
  assign sig = sig_q;
`else
  logic w_sig_unused;
  assign w_sig_unused = ^sig_d;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mioc_gate_pattern_checker.sv
// ============================================================================
// Module  : tb_mioc_gate_pattern_checker
// Brief   : Directed bench with a cycle-level reference of the pattern sweep.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mioc_gate_pattern_checker;

  localparam int          SC = 4;
  localparam int          P  = SC + 4;
  localparam logic [15:0] TT = 16'h7FFF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       z;
  logic       in1, in2, in3, in4, busy, done, pass;
  logic [4:0] err_cnt;
  logic [3:0] first_fail;
`ifdef MIOC_SIGNATURE_EN
  logic [15:0] sig;
`endif

  int   n_chk = 0;
  int   n_err = 0;
  int   mode  = 0;
  logic zx    = 1'b1;
  logic [3:0] d1 = 4'd0, d2 = 4'd0;

  mioc_gate_pattern_checker #(.SETTLE_CYC(SC), .EXPECT_TT(TT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .z(z),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_fail(first_fail)
`ifdef MIOC_SIGNATURE_EN
    , .sig(sig)
`endif
  );

  always #5 clk = ~clk;

  // Gate response for each mode: 0 ideal, 1 stuck-at-1, 2 stuck-at-0, 3 ideal but wrong at pattern 5
  function automatic logic zfun(input int m, input logic [3:0] p);
    logic [15:0] tt;
    tt = TT;
    case (m)
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return (p == 4'd5) ? ~tt[p] : tt[p];
      default: return tt[p];
    endcase
  endfunction

  function automatic logic [4:0] model_err(input int m);
    logic [4:0] c;
    logic [15:0] tt;
    tt = TT;
    c = 5'd0;
    for (int p = 0; p < 16; p++)
      if (zfun(m, 4'(p)) != tt[p]) c = c + 5'd1;
    return c;
  endfunction

  function automatic logic [3:0] model_ff(input int m);
    logic [15:0] tt;
    tt = TT;
    for (int p = 0; p < 16; p++)
      if (zfun(m, 4'(p)) != tt[p]) return 4'(p);
    return 4'd0;
  endfunction

  function automatic logic [15:0] model_sig(input int m);
    logic [15:0] s;
    s = 16'hFFFF;
    for (int p = 0; p < 16; p++)
      s = {s[14:0], 1'b0} ^ ((s[15] ^ zfun(m, 4'(p))) ? 16'h1021 : 16'h0000);
    return s;
  endfunction

  // Ideal gate with two cycles of delay from its inputs
  always @(posedge clk) begin
    d1 <= {in1, in2, in3, in4};
    d2 <= d1;
  end
  assign z = zx ? 1'bx : zfun(mode, d2);

  // Reference: run_c counts edges since the accepting edge, -1 when idle
  int          run_c = -1;
  logic [4:0]  e_err = 5'd0;
  logic [3:0]  e_ff = 4'd0;
  logic        e_pass = 1'b0;
  logic [15:0] e_sig = 16'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_c <= -1; e_err <= 5'd0; e_ff <= 4'd0; e_pass <= 1'b0; e_sig <= 16'd0;
    end else if (run_c < 0) begin
      if (start) begin
        run_c <= 0; e_err <= 5'd0; e_ff <= 4'd0; e_pass <= 1'b0; e_sig <= 16'hFFFF;
      end
    end else if (run_c == 16 * P) begin
      run_c  <= -1;
      e_err  <= model_err(mode);
      e_ff   <= model_ff(mode);
      e_pass <= (model_err(mode) == 5'd0);
      e_sig  <= model_sig(mode);
    end else begin
      run_c <= run_c + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int ep;
    ep = (run_c >= 1 && run_c <= 16 * P) ? (run_c - 1) / P : 0;
    chk("pattern", 32'({in1, in2, in3, in4}), 32'(ep));
    chk("busy", 32'(busy), 32'(run_c >= 0));
    chk("done", 32'(done), 32'(run_c == 16 * P));
    chk("pass", 32'(pass), 32'(e_pass));
    if (run_c < 0) begin
      chk("err_cnt", 32'(err_cnt), 32'(e_err));
      chk("first_fail", 32'(first_fail), 32'(e_ff));
`ifdef MIOC_SIGNATURE_EN
      chk("sig", 32'(sig), 32'(e_sig));
`endif
    end
  end

  task automatic wait_done(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 3000);
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_once(input int m, output int k);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2;
    logic [15:0] sig_a, sig_b;
    sig_a = 16'd0;
    sig_b = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pins", 32'({in1, in2, in3, in4}), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    zx    = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_once(0, k);
    chk("ideal_done_cycle", 32'(k), 32'd129);
    chk("ideal_err", 32'(err_cnt), 32'd0);
    chk("ideal_pass", 32'(pass), 32'd1);
`ifdef MIOC_SIGNATURE_EN
    sig_a = sig;
`endif

    run_once(1, k);
    chk("s1_err", 32'(err_cnt), 32'd1);
    chk("s1_ff", 32'(first_fail), 32'hF);
    chk("s1_pass", 32'(pass), 32'd0);

    run_once(2, k);
    chk("s0_err", 32'(err_cnt), 32'd15);
    chk("s0_ff", 32'(first_fail), 32'h0);
    chk("s0_pass", 32'(pass), 32'd0);

    // start held high: second run begins the cycle after DONE is exited
    mode  = 0;
    start = 1'b1;
    wait_done(k);
    chk("hold_first_done", 32'(k), 32'd129);
    wait_done(k2);
    chk("hold_second_done", 32'(k2), 32'd130);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold_idle_busy", 32'(busy), 32'd0);

    // abort at pattern 7
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while ({in1, in2, in3, in4} != 4'd7 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reach7", 32'({in1, in2, in3, in4}), 32'd7);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_once(0, k);
    chk("post_abort_done_cycle", 32'(k), 32'd129);
    chk("post_abort_pass", 32'(pass), 32'd1);

    run_once(3, k);
    chk("inj_err", 32'(err_cnt), 32'd1);
    chk("inj_ff", 32'(first_fail), 32'd5);
`ifdef MIOC_SIGNATURE_EN
    sig_b = sig;
    n_chk++;
    if (sig_b === sig_a) begin
      n_err++;
      $display("FAIL sig_inject: got %0h, required to differ from %0h", sig_b, sig_a);
    end
    run_once(0, k);
    chk("sig_repeat", 32'(sig), 32'(sig_a));
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
